// File: rtl/fp_pkg.sv
// Shared FP constants, field layout and scan FSM encoding for the FPU reducers.
// Purely declarative; no logic, no latency.
// No flow control of its own.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    localparam logic [31:0] FP_CNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;

    // Scan FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (&x[EXP_MSB:EXP_LSB]) && (|x[MANT_MSB:0]);
    endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// Sign-aware IEEE-754 single-precision ordering of a against b.
// Combinational, zero latency.
// No flow control; NaN on b is never presented by the scanner.
module fp_order_cmp
    import fp_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        lt_o,
    output logic        gt_o,
    output logic        eq_o,
    output logic        a_nan_o
);

    fp32_t       a, b;
    logic [30:0] a_mag, b_mag;
    logic        both_zero, mag_lt, mag_gt;

    assign a         = a_i;
    assign b         = b_i;
    assign a_mag     = {a.exp, a.mant};
    assign b_mag     = {b.exp, b.mant};
    assign both_zero = (a_mag == '0) && (b_mag == '0);
    assign mag_lt    = a_mag < b_mag;
    assign mag_gt    = a_mag > b_mag;
    assign a_nan_o   = fp_is_nan(a_i);

    // Order by sign first; negatives reverse the magnitude ordering; +0 == -0
    always_comb begin
        lt_o = 1'b0;
        gt_o = 1'b0;
        eq_o = 1'b0;
        if (both_zero) begin
            eq_o = 1'b1;
        end else if (a.sign != b.sign) begin
            lt_o = a.sign;
            gt_o = b.sign;
        end else if (!a.sign) begin
            lt_o = mag_lt;
            gt_o = mag_gt;
            eq_o = !mag_lt && !mag_gt;
        end else begin
            lt_o = mag_gt;
            gt_o = mag_lt;
            eq_o = !mag_lt && !mag_gt;
        end
    end

endmodule

// File: rtl/fp_minmax_scan.sv
// Streaming min/max (with indices) over a burst of len FP32 operands.
// Start-to-done n+1 cycles for n back-to-back beats; done pulses one cycle after the last beat.
// in_ready_o is a registered state decode; in_valid_i bubbles stall without state change.
module fp_minmax_scan
    import fp_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [CW-1:0] len_i,
    input  logic          in_valid_i,
    input  logic [W-1:0]  in_data_i,
    output logic          in_ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  min_out_o,
    output logic [W-1:0]  max_out_o,
    output logic [CW-1:0] min_idx_o,
    output logic [CW-1:0] max_idx_o,
    output logic          found_o,
    output logic          inv_o
);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [W-1:0]  min_q, min_d, max_q, max_d;
    logic [CW-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic          found_q, found_d, inv_q, inv_d;

    logic mn_lt, mn_gt, mn_eq, beat_nan;
    logic mx_lt, mx_gt, mx_eq, mx_nan;
    logic cmp_unused;
    logic acc, last_beat;

    fp_order_cmp u_cmp_min (
        .a_i     (in_data_i),
        .b_i     (min_q),
        .lt_o    (mn_lt),
        .gt_o    (mn_gt),
        .eq_o    (mn_eq),
        .a_nan_o (beat_nan)
    );

    fp_order_cmp u_cmp_max (
        .a_i     (in_data_i),
        .b_i     (max_q),
        .lt_o    (mx_lt),
        .gt_o    (mx_gt),
        .eq_o    (mx_eq),
        .a_nan_o (mx_nan)
    );

    // Only min-side lt and max-side gt drive updates; ties keep the earlier index
    assign cmp_unused = &{1'b0, mn_gt, mn_eq, mx_lt, mx_eq, mx_nan};

    assign in_ready_o = (state_q == ST_FIRST) || (state_q == ST_SCAN);
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign min_out_o  = min_q;
    assign max_out_o  = max_q;
    assign min_idx_o  = min_idx_q;
    assign max_idx_o  = max_idx_q;
    assign found_o    = found_q;
    assign inv_o      = inv_q;

    assign acc       = in_valid_i && in_ready_o;
    assign last_beat = (cnt_q == len_q - 1'b1);

    // Next-state: burst setup, per-beat seed/update, and canonical-NaN fill when nothing valid was seen
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        found_d   = found_q;
        inv_d     = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    found_d = 1'b0;
                    inv_d   = 1'b0;
                    if (len_i == '0) begin
                        state_d   = ST_DONE;
                        min_d     = FP_CNAN;
                        max_d     = FP_CNAN;
                        min_idx_d = '0;
                        max_idx_d = '0;
                    end else begin
                        state_d = ST_FIRST;
                        len_d   = len_i;
                        cnt_d   = '0;
                    end
                end
            end
            ST_FIRST, ST_SCAN: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_nan) begin
                        inv_d = 1'b1;
                    end else if (state_q == ST_FIRST) begin
                        state_d   = ST_SCAN;
                        found_d   = 1'b1;
                        min_d     = in_data_i;
                        max_d     = in_data_i;
                        min_idx_d = cnt_q;
                        max_idx_d = cnt_q;
                    end else begin
                        if (mn_lt) begin
                            min_d     = in_data_i;
                            min_idx_d = cnt_q;
                        end
                        if (mx_gt) begin
                            max_d     = in_data_i;
                            max_idx_d = cnt_q;
                        end
                    end
                    if (last_beat) begin
                        state_d = ST_DONE;
                        if (!found_d) begin
                            min_d     = FP_CNAN;
                            max_d     = FP_CNAN;
                            min_idx_d = '0;
                            max_idx_d = '0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous abort
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            found_q   <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            found_q   <= found_d;
            inv_q     <= inv_d;
        end
    end

endmodule

// File: tb/tb_fp_minmax_scan.sv
// Directed bench for fp_minmax_scan: hand-computed results, latency and reset-abort checks.
// Inputs driven #1 after the rising edge; outputs sampled there too.
// Every bounded loop has a cycle budget.
module tb_fp_minmax_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready, busy, done, found, inv;
    logic [31:0] min_out, max_out;
    logic [7:0]  min_idx, max_idx;

    int n_chk = 0;
    int n_err = 0;
    int done_seen = 0;
    logic [31:0] vec [0:7];

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_seen <= done_seen + 1;

    fp_minmax_scan #(.W(32), .CW(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .len_i      (len),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .busy_o     (busy),
        .done_o     (done),
        .min_out_o  (min_out),
        .max_out_o  (max_out),
        .min_idx_o  (min_idx),
        .max_idx_o  (max_idx),
        .found_o    (found),
        .inv_o      (inv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [31:0] mn, input logic [7:0] mni,
                             input logic [31:0] mx, input logic [7:0] mxi,
                             input logic fnd, input logic iv);
        check({tag, "/min"},  min_out, mn);
        check({tag, "/mini"}, min_idx, mni);
        check({tag, "/max"},  max_out, mx);
        check({tag, "/maxi"}, max_idx, mxi);
        check({tag, "/found"}, found, fnd);
        check({tag, "/inv"},  inv, iv);
    endtask

    // Runs a burst of n beats from vec; returns with done expected high
    task automatic burst(input string tag, input int n, input bit bubbles, input bit mid_start);
        int acc_cnt;
        int cyc;
        start = 1'b1;
        len   = 8'(n);
        step();
        start = 1'b0;
        len   = 8'd0;
        check({tag, "/rdy"}, in_ready, 1'b1);
        acc_cnt = 0;
        cyc     = 0;
        while (acc_cnt < n && cyc < 64) begin
            if (bubbles && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                if (mid_start && cyc == 3) begin
                    start = 1'b1;
                    len   = 8'd2;
                end
            end else begin
                in_valid = 1'b1;
                in_data  = vec[acc_cnt];
                acc_cnt++;
            end
            step();
            start    = 1'b0;
            len      = 8'd0;
            in_valid = 1'b0;
            cyc++;
            if (acc_cnt < n) begin
                check({tag, "/early"}, done, 1'b0);
                check({tag, "/busy"}, busy, 1'b1);
            end
        end
        check({tag, "/cyc"}, cyc, bubbles ? (2 * n - 1) : n);
        check({tag, "/done"}, done, 1'b1);
    endtask

    task automatic after_done(input string tag);
        step();
        check({tag, "/pulse"}, done, 1'b0);
        check({tag, "/idle"}, busy, 1'b0);
    endtask

    task automatic load_t1();
        vec[0] = 32'h3F80_0000;
        vec[1] = 32'hC000_0000;
        vec[2] = 32'h4040_0000;
        vec[3] = 32'hBF00_0000;
    endtask

    initial begin
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        len      = 8'd0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        step();
        step();
        check("rst/rdy",  in_ready, 1'b0);
        check("rst/busy", busy, 1'b0);
        check("rst/done", done, 1'b0);
        check_res("rst", 32'd0, 8'd0, 32'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Operands offered while idle are ignored
        in_valid = 1'b1;
        in_data  = 32'hC000_0000;
        step();
        in_valid = 1'b0;
        check("idle/rdy", in_ready, 1'b0);
        check("idle/min", min_out, 32'd0);

        load_t1();
        burst("t1", 4, 1'b0, 1'b0);
        check_res("t1", 32'hC000_0000, 8'd1, 32'h4040_0000, 8'd2, 1'b1, 1'b0);
        after_done("t1");

        vec[0] = 32'h7FC0_0001;
        vec[1] = 32'h40A0_0000;
        vec[2] = 32'hFF80_0000;
        burst("t2", 3, 1'b0, 1'b0);
        check_res("t2", 32'hFF80_0000, 8'd2, 32'h40A0_0000, 8'd1, 1'b1, 1'b1);
        after_done("t2");

        vec[0] = 32'h0000_0000;
        vec[1] = 32'h8000_0000;
        vec[2] = 32'h0000_0000;
        burst("t3", 3, 1'b0, 1'b0);
        check_res("t3", 32'h0000_0000, 8'd0, 32'h0000_0000, 8'd0, 1'b1, 1'b0);
        after_done("t3");

        // Zero-length burst
        start = 1'b1;
        len   = 8'd0;
        step();
        start = 1'b0;
        check("len0/done",  done, 1'b1);
        check("len0/min",   min_out, 32'h7FC0_0000);
        check("len0/max",   max_out, 32'h7FC0_0000);
        check("len0/found", found, 1'b0);
        check("len0/inv",   inv, 1'b0);
        after_done("len0");

        vec[0] = 32'h7FC0_0000;
        vec[1] = 32'hFFFF_FFFF;
        burst("t4", 2, 1'b0, 1'b0);
        check("t4/min",   min_out, 32'h7FC0_0000);
        check("t4/max",   max_out, 32'h7FC0_0000);
        check("t4/found", found, 1'b0);
        check("t4/inv",   inv, 1'b1);
        after_done("t4");

        vec[0] = 32'h4000_0000;
        vec[1] = 32'h40E0_0000;
        vec[2] = 32'hBF80_0000;
        vec[3] = 32'h3F00_0000;
        vec[4] = 32'h7F80_0000;
        burst("t5", 5, 1'b1, 1'b1);
        check_res("t5", 32'hBF80_0000, 8'd2, 32'h7F80_0000, 8'd4, 1'b1, 1'b0);
        after_done("t5");

        // Reset mid-burst after two beats
        load_t1();
        start = 1'b1;
        len   = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            step();
        end
        in_valid = 1'b0;
        d0 = done_seen;
        #2 rst = 1'b1;
        #1;
        check("abort/rdy",  in_ready, 1'b0);
        check("abort/busy", busy, 1'b0);
        check("abort/done", done, 1'b0);
        check_res("abort", 32'd0, 8'd0, 32'd0, 8'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort/nodone", done_seen, d0);
        check("abort/idle",   busy, 1'b0);

        burst("t6", 4, 1'b0, 1'b0);
        check_res("t6", 32'hC000_0000, 8'd1, 32'h4040_0000, 8'd2, 1'b1, 1'b0);
        after_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
